reg_file_rename: RTL and testbench

- Architectural register file with per-register rename tags; the consumer end of the reorder-buffer issue-rename and commit interfaces.
- At issue, records which RoB entry will produce each destination register.
- At commit, writes retired values and clears the tag when it still matches.
- Provides two combinational source-operand lookups (value, busy, producer tag) to the issue stage, and drops all renames on a pipeline flush.

---
 rtl/reg_file_rename.sv | 127 ++++++++++++
 tb/tb_reg_file_rename.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/reg_file_rename.sv
// reg_file_rename
// ---------------
// Architectural register file with per-register rename tags. It sits at the
// consumer end of the reorder buffer:
//   - At issue, it records which RoB entry will produce each destination.
//   - At commit, it writes retired values and clears the tag if it still
//     matches.
//   - Two combinational source lookups feed the issue stage.
//   - A flush drops every outstanding rename.
//
// Ports
//   clk_in, rst_in      clock, synchronous active-high reset
//   rdy_in              state frozen when low (reads stay live)
//   issue_rd/issue_tag  rename of a destination to a RoB tail index (rd 0 = none)
//   commit_rd/_value/_tag
//                       retiring write from the RoB head (rd 0 = none)
//   flush               RoB clear; drops all renames, still performs the commit
//   rs1_id, rs2_id      source register indices
//   rsX_value/_busy/_tag
//                       source value, awaiting-producer flag, producer tag
//   commit_count        (REG_FILE_COMMIT_CNT_EN only) retired-write counter
//
// Optional feature: define REG_FILE_COMMIT_CNT_EN to add the commit_count port.
module reg_file_rename #(
    parameter int ROB_BITS = 4,
    parameter int NREG     = 32
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic [4:0]          issue_rd,
    input  logic [ROB_BITS-1:0] issue_tag,
    input  logic [4:0]          commit_rd,
    input  logic [31:0]         commit_value,
    input  logic [ROB_BITS-1:0] commit_tag,
    input  logic                flush,
    input  logic [4:0]          rs1_id,
    input  logic [4:0]          rs2_id,
    output logic [31:0]         rs1_value,
    output logic                rs1_busy,
    output logic [ROB_BITS-1:0] rs1_tag,
    output logic [31:0]         rs2_value,
    output logic                rs2_busy,
    output logic [ROB_BITS-1:0] rs2_tag
`ifdef REG_FILE_COMMIT_CNT_EN
    ,
    output logic [31:0]         commit_count
`endif
);

    logic [31:0]         val  [NREG];
    logic                busy [NREG];
    logic [ROB_BITS-1:0] tag  [NREG];

    logic commit_en;
    logic issue_en;

    assign commit_en = (commit_rd != 5'd0);
    assign issue_en  = (issue_rd != 5'd0) && !flush;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                val[i]  <= '0;
                busy[i] <= 1'b0;
                tag[i]  <= '0;
            end
        end else if (rdy_in) begin
            // The commit is performed even on a flush cycle (a jalr retires and
            // flushes together); the flush loop below overrides its busy clear.
            if (commit_en) begin
                val[commit_rd] <= commit_value;
                if (busy[commit_rd] && (tag[commit_rd] == commit_tag))
                    busy[commit_rd] <= 1'b0;
            end
            if (flush) begin
                for (int unsigned i = 0; i < NREG; i++) begin
                    busy[i] <= 1'b0;
                    tag[i]  <= '0;
                end
            end else if (issue_en) begin
                // Placed after the commit so a same-register issue wins busy/tag.
                busy[issue_rd] <= 1'b1;
                tag[issue_rd]  <= issue_tag;
            end
        end
    end

    // Source lookups. These reflect the pre-edge state plus a bypass of the
    // commit in flight. The same-cycle issue is deliberately not bypassed.
    logic hit1, hit2, match1, match2;

    always_comb begin
        hit1   = commit_en && (commit_rd == rs1_id) && rdy_in;
        hit2   = commit_en && (commit_rd == rs2_id) && rdy_in;
        match1 = hit1 && busy[rs1_id] && (tag[rs1_id] == commit_tag);
        match2 = hit2 && busy[rs2_id] && (tag[rs2_id] == commit_tag);

        rs1_value = '0;
        rs1_busy  = 1'b0;
        rs1_tag   = '0;
        if (rs1_id != 5'd0) begin
            rs1_value = hit1 ? commit_value : val[rs1_id];
            rs1_busy  = busy[rs1_id] && !match1;
            rs1_tag   = tag[rs1_id];
        end

        rs2_value = '0;
        rs2_busy  = 1'b0;
        rs2_tag   = '0;
        if (rs2_id != 5'd0) begin
            rs2_value = hit2 ? commit_value : val[rs2_id];
            rs2_busy  = busy[rs2_id] && !match2;
            rs2_tag   = tag[rs2_id];
        end
    end

`ifdef REG_FILE_COMMIT_CNT_EN
    always_ff @(posedge clk_in) begin
        if (rst_in)
            commit_count <= '0;
        else if (rdy_in && commit_en)
            commit_count <= commit_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_reg_file_rename.sv
module tb_reg_file_rename;

    localparam int RB = 4;

    logic          clk_in = 1'b0;
    logic          rst_in, rdy_in, flush;
    logic [4:0]    issue_rd, commit_rd, rs1_id, rs2_id;
    logic [RB-1:0] issue_tag, commit_tag;
    logic [31:0]   commit_value;
    logic [31:0]   rs1_value, rs2_value;
    logic          rs1_busy, rs2_busy;
    logic [RB-1:0] rs1_tag, rs2_tag;
`ifdef REG_FILE_COMMIT_CNT_EN
    logic [31:0]   commit_count;
`endif

    always #5 clk_in = ~clk_in;

    reg_file_rename #(.ROB_BITS(RB), .NREG(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_rd(issue_rd), .issue_tag(issue_tag),
        .commit_rd(commit_rd), .commit_value(commit_value), .commit_tag(commit_tag),
        .flush(flush), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_value(rs1_value), .rs1_busy(rs1_busy), .rs1_tag(rs1_tag),
        .rs2_value(rs2_value), .rs2_busy(rs2_busy), .rs2_tag(rs2_tag)
`ifdef REG_FILE_COMMIT_CNT_EN
        , .commit_count(commit_count)
`endif
    );

    // Reference model: architectural value, outstanding producer (or none),
    // and the last producer tag recorded for each register.
    logic [31:0]   m_val   [32];
    bit            m_renamed [32];
    logic [RB-1:0] m_tag   [32];
    int unsigned   m_cnt;

    typedef struct {
        string         name;
        logic [31:0]   v1, v2;
        logic          b1, b2;
        logic [RB-1:0] t1, t2;
        logic [31:0]   cnt;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    function automatic void m_read(input logic [4:0] id, output logic [31:0] v,
                                   output logic b, output logic [RB-1:0] t);
        bit hit;
        if (id == 0) begin
            v = 0; b = 0; t = 0;
        end else begin
            hit = rdy_in && (commit_rd == id);
            v   = hit ? commit_value : m_val[id];
            b   = m_renamed[id] && !(hit && m_tag[id] == commit_tag);
            t   = m_tag[id];
        end
    endfunction

    function automatic void m_clear_all(input bit vals);
        for (int i = 0; i < 32; i++) begin
            if (vals) m_val[i] = 0;
            m_renamed[i] = 0;
            m_tag[i] = 0;
        end
    endfunction

    function automatic void m_edge();
        if (rst_in) begin
            m_clear_all(1);
            m_cnt = 0;
        end else if (rdy_in) begin
            if (commit_rd != 0) begin
                m_val[commit_rd] = commit_value;
                if (m_renamed[commit_rd] && m_tag[commit_rd] == commit_tag)
                    m_renamed[commit_rd] = 0;
                m_cnt++;
            end
            if (flush) m_clear_all(0);
            else if (issue_rd != 0) begin
                m_renamed[issue_rd] = 1;
                m_tag[issue_rd] = issue_tag;
            end
        end
    endfunction

    // One cycle: drive inputs just after the edge, queue the expected read
    // response for this cycle, then advance the model for the coming edge.
    task automatic step(input string name, input logic rst, input logic rdy,
                        input logic [4:0] ird, input logic [RB-1:0] itag,
                        input logic [4:0] crd, input logic [31:0] cval,
                        input logic [RB-1:0] ctag, input logic fl,
                        input logic [4:0] r1, input logic [4:0] r2);
        exp_t e;
        @(posedge clk_in);
        #1;
        rst_in = rst; rdy_in = rdy; issue_rd = ird; issue_tag = itag;
        commit_rd = crd; commit_value = cval; commit_tag = ctag; flush = fl;
        rs1_id = r1; rs2_id = r2;
        e.name = name;
        m_read(r1, e.v1, e.b1, e.t1);
        m_read(r2, e.v2, e.b2, e.t2);
        e.cnt = m_cnt;
        exp_q.push_back(e);
        m_edge();
    endtask

    // Monitor: the read ports are always valid; compare mid-cycle.
    always @(negedge clk_in) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if ({rs1_value, rs1_busy, rs1_tag, rs2_value, rs2_busy, rs2_tag} !==
                {e.v1, e.b1, e.t1, e.v2, e.b2, e.t2}) begin
                errors++;
                $display("FAIL %s: got rs1=%h/%b/%0d rs2=%h/%b/%0d required rs1=%h/%b/%0d rs2=%h/%b/%0d",
                         e.name, rs1_value, rs1_busy, rs1_tag, rs2_value, rs2_busy, rs2_tag,
                         e.v1, e.b1, e.t1, e.v2, e.b2, e.t2);
            end
`ifdef REG_FILE_COMMIT_CNT_EN
            checks++;
            if (commit_count !== e.cnt) begin
                errors++;
                $display("FAIL %s count: got %0d required %0d", e.name, commit_count, e.cnt);
            end
`endif
        end
    end

    initial begin
        rst_in = 1; rdy_in = 1; flush = 0; issue_rd = 0; issue_tag = 0;
        commit_rd = 0; commit_value = 0; commit_tag = 0; rs1_id = 0; rs2_id = 0;
        m_clear_all(1);
        m_cnt = 0;
        repeat (2) @(posedge clk_in);

        //    name          rst rdy ird itag crd cval           ctag fl r1 r2
        step("reset_read",   0, 1, 0, 0, 0, 32'h0,          0, 0, 5, 0);
        step("issue3",       0, 1, 3, 2, 0, 32'h0,          0, 0, 3, 0);
        step("busy3",        0, 1, 0, 0, 0, 32'h0,          0, 0, 3, 0);
        step("commit3_byp",  0, 1, 0, 0, 3, 32'h1234,       2, 0, 3, 3);
        step("commit3_post", 0, 1, 0, 0, 0, 32'h0,          0, 0, 3, 0);
        step("issue4a",      0, 1, 4, 1, 0, 32'h0,          0, 0, 4, 0);
        step("issue4b",      0, 1, 4, 6, 0, 32'h0,          0, 0, 4, 0);
        step("stale4_byp",   0, 1, 0, 0, 4, 32'hAA,         1, 0, 4, 0);
        step("stale4_post",  0, 1, 0, 0, 0, 32'h0,          0, 0, 4, 0);
        step("issue7",       0, 1, 7, 3, 0, 32'h0,          0, 0, 7, 0);
        step("same7_byp",    0, 1, 7, 5, 7, 32'h55,         3, 0, 7, 0);
        step("same7_post",   0, 1, 0, 0, 0, 32'h0,          0, 0, 7, 0);
        step("issue1",       0, 1, 1, 1, 0, 32'h0,          0, 0, 1, 0);
        step("issue2",       0, 1, 2, 2, 0, 32'h0,          0, 0, 1, 0);
        step("issue9",       0, 1, 9, 3, 0, 32'h0,          0, 0, 1, 2);
        step("flush_byp",    0, 1, 2, 7, 1, 32'h80000004,   1, 1, 1, 2);
        step("flush_post12", 0, 1, 0, 0, 0, 32'h0,          0, 0, 1, 2);
        step("flush_post9",  0, 1, 0, 0, 0, 32'h0,          0, 0, 9, 7);
        step("r0_write",     0, 1, 0, 4, 0, 32'hFFFFFFFF,   4, 0, 0, 8);
        step("r0_read",      0, 1, 0, 0, 0, 32'h0,          0, 0, 0, 8);
        step("rdy0_commit8", 0, 0, 8, 3, 8, 32'hDEADBEEF,   0, 0, 8, 0);
        step("rdy0_post",    0, 1, 0, 0, 0, 32'h0,          0, 0, 8, 0);
        step("pre_rst",      0, 1, 5, 9, 0, 32'h0,          0, 0, 5, 3);
        step("rst_mid",      1, 1, 6, 2, 3, 32'h77,         0, 1, 3, 5);
        step("rst_post",     0, 1, 0, 0, 0, 32'h0,          0, 0, 3, 5);

        // Randomised traffic over a small register window so hits are common.
        for (int n = 0; n < 3000; n++) begin
            logic [4:0]    crd, ird;
            logic [RB-1:0] ctag;
            crd  = 5'($urandom_range(0, 7));
            ird  = 5'($urandom_range(0, 7));
            ctag = ($urandom_range(0, 1) == 0) ? m_tag[crd] : RB'($urandom);
            step("random",
                 ($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0),
                 ird, RB'($urandom), crd, $urandom, ctag,
                 ($urandom_range(0, 19) == 0),
                 5'($urandom_range(0, 8)), 5'($urandom_range(0, 8)));
        end

        repeat (3) @(posedge clk_in);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
